// File: rtl/snd_dma_ctrl.sv
// ---------------------------------------------------------------------------
// snd_dma_ctrl
//
// Read-DMA scheduler for the sound subsystem. Fetches PCM sample words from a
// DDR buffer with fixed 4-beat INCR bursts on the AXI read channel and pushes
// every returned beat straight into the sample FIFO feeding the I2S
// serializer. A burst is only requested when the FIFO has room for all four
// words, so the FIFO can never overflow. Optionally loops over the buffer.
//
// Ports
//   ACLK, ARST          clock, synchronous active-high reset
//   M_AXI_AR*           read address channel (ARLEN/ARSIZE/ARBURST constant)
//   M_AXI_R*            read data channel
//   FIFO_FREE           free word slots in the sample FIFO
//   FIFO_WREN/WDATA     FIFO push strobe/data (combinational from R channel)
//   WRADDR/BYTEEN/WREN/WDATA   register write port
//   RDADDR/RDEN/RDATA          register read port (RDATA registered)
//
// Register map (byte offsets)
//   0x0000 SNDADDR  buffer base, bits [3:0] always 0
//   0x0004 SNDSIZE  buffer length in bytes, bits [3:0] always 0
//   0x0008 SNDCTRL  bit0 ENABLE, bit1 LOOP
//   0x000C SNDSTAT  bit0 BUSY, bit1 RESPERR (sticky, RO)
// ---------------------------------------------------------------------------
module snd_dma_ctrl #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_FIFO_CNT_WIDTH   = 10
) (
  input  logic                          ACLK,
  input  logic                          ARST,

  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,

  input  logic [C_FIFO_CNT_WIDTH-1:0]   FIFO_FREE,
  output logic                          FIFO_WREN,
  output logic [C_M_AXI_DATA_WIDTH-1:0] FIFO_WDATA,

  input  logic [15:0]                   WRADDR,
  input  logic [3:0]                    BYTEEN,
  input  logic                          WREN,
  input  logic [31:0]                   WDATA,
  input  logic [15:0]                   RDADDR,
  input  logic                          RDEN,
  output logic [31:0]                   RDATA
);

  // -------------------------------------------------------------------------
  // State | meaning
  // IDLE  | not busy; waits for an ENABLE rising edge with SNDSIZE != 0
  // WAIT  | between bursts; waits for 4 free FIFO slots (or ENABLE=0)
  // ADDR  | ARVALID asserted with ARADDR=cur_addr until ARREADY
  // DATA  | RREADY asserted; every beat pushed, RLAST ends the burst
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [15:0] REG_SNDADDR = 16'h0000;
  localparam logic [15:0] REG_SNDSIZE = 16'h0004;
  localparam logic [15:0] REG_SNDCTRL = 16'h0008;
  localparam logic [15:0] REG_SNDSTAT = 16'h000C;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(16);
  localparam logic [C_FIFO_CNT_WIDTH-1:0]   BURST_WORDS = C_FIFO_CNT_WIDTH'(4);

  // Software-visible registers. Address and size keep only bits [31:4], so
  // the forced-zero low nibble needs no extra logic.
  logic [27:0] snd_addr;
  logic [27:0] snd_size;
  logic        ctrl_enable;
  logic        ctrl_loop;
  logic        stat_resperr;
  logic        enable_q;

  // Transfer state, counted in 16-byte bursts for remain.
  state_t                        state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [27:0]                   remain;
  logic                          arvalid_r;
  logic                          rready_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_r;

  logic                          busy;
  logic                          beat;
  logic                          burst_done;
  logic                          last_burst;
  logic                          reload_ok;
  logic                          start_edge;
  logic                          eob_clr;
  logic                          wr_addr_hit;
  logic                          wr_size_hit;
  logic                          wr_ctrl_hit;
  logic [31:0]                   addr_merged;
  logic [31:0]                   size_merged;
  logic [C_M_AXI_ADDR_WIDTH-1:0] load_addr;
  logic [31:0]                   rd_mux;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  assign M_AXI_ARLEN   = 8'd3;
  assign M_AXI_ARSIZE  = 3'd2;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_RREADY  = rready_r;

  // Pushes go straight through; data is gated so the FIFO bus is quiet
  // whenever no beat is being accepted.
  assign beat       = M_AXI_RVALID & rready_r;
  assign FIFO_WREN  = beat;
  assign FIFO_WDATA = beat ? M_AXI_RDATA : '0;

  assign busy        = (state != ST_IDLE);
  assign burst_done  = (state == ST_DATA) & beat & M_AXI_RLAST;
  assign last_burst  = (remain == 28'd1);
  assign reload_ok   = ctrl_loop & (snd_size != 28'd0);
  assign start_edge  = ctrl_enable & ~enable_q & (snd_size != 28'd0);
  assign load_addr   = C_M_AXI_ADDR_WIDTH'({snd_addr, 4'b0000});

  // End of buffer without looping drops ENABLE; a software write to
  // SNDCTRL in the same cycle takes priority in the register block.
  assign eob_clr = burst_done & last_burst & ~reload_ok;

  assign wr_addr_hit = WREN & (WRADDR == REG_SNDADDR);
  assign wr_size_hit = WREN & (WRADDR == REG_SNDSIZE);
  assign wr_ctrl_hit = WREN & (WRADDR == REG_SNDCTRL) & BYTEEN[0];

  assign addr_merged = be_merge({snd_addr, 4'b0000}, WDATA, BYTEEN);
  assign size_merged = be_merge({snd_size, 4'b0000}, WDATA, BYTEEN);

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      snd_addr     <= '0;
      snd_size     <= '0;
      ctrl_enable  <= 1'b0;
      ctrl_loop    <= 1'b0;
      stat_resperr <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      enable_q <= ctrl_enable;

      if (wr_addr_hit) begin
        snd_addr <= addr_merged[31:4];
      end
      if (wr_size_hit) begin
        snd_size <= size_merged[31:4];
      end

      if (wr_ctrl_hit) begin
        ctrl_enable <= WDATA[0];
        ctrl_loop   <= WDATA[1];
      end else if (eob_clr) begin
        ctrl_enable <= 1'b0;
      end

      // An error beat in the same cycle as the clearing write stays visible.
      if (beat && (M_AXI_RRESP != 2'b00)) begin
        stat_resperr <= 1'b1;
      end else if (wr_ctrl_hit && WDATA[0]) begin
        stat_resperr <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (RDADDR)
      REG_SNDADDR: rd_mux = {snd_addr, 4'b0000};
      REG_SNDSIZE: rd_mux = {snd_size, 4'b0000};
      REG_SNDCTRL: rd_mux = {30'd0, ctrl_loop, ctrl_enable};
      REG_SNDSTAT: rd_mux = {30'd0, stat_resperr, busy};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      RDATA <= '0;
    end else if (RDEN) begin
      RDATA <= rd_mux;
    end
  end

  // -------------------------------------------------------------------------
  // Burst sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      araddr_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            cur_addr <= load_addr;
            remain   <= snd_size;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!ctrl_enable) begin
            state <= ST_IDLE;
          end else if (FIFO_FREE >= BURST_WORDS) begin
            arvalid_r <= 1'b1;
            araddr_r  <= cur_addr;
            state     <= ST_ADDR;
          end
        end

        // ENABLE is deliberately not looked at here or in DATA: an issued
        // AXI transaction always runs to completion.
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (burst_done) begin
            rready_r <= 1'b0;
            if (last_burst) begin
              if (reload_ok) begin
                cur_addr <= load_addr;
                remain   <= snd_size;
                state    <= ST_WAIT;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cur_addr <= cur_addr + BURST_BYTES;
              remain   <= remain - 28'd1;
              state    <= ST_WAIT;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snd_dma_ctrl.sv
`timescale 1ns/1ps
module tb_snd_dma_ctrl;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [9:0]  FIFO_FREE;
  logic        FIFO_WREN;
  logic [31:0] FIFO_WDATA;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;

  always #5 ACLK = ~ACLK;

  snd_dma_ctrl dut (
    .ACLK          (ACLK),
    .ARST          (ARST),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .FIFO_FREE     (FIFO_FREE),
    .FIFO_WREN     (FIFO_WREN),
    .FIFO_WDATA    (FIFO_WDATA),
    .WRADDR        (WRADDR),
    .BYTEEN        (BYTEEN),
    .WREN          (WREN),
    .WDATA         (WDATA),
    .RDADDR        (RDADDR),
    .RDEN          (RDEN),
    .RDATA         (RDATA)
  );

  localparam logic [15:0] A_ADDR = 16'h0000;
  localparam logic [15:0] A_SIZE = 16'h0004;
  localparam logic [15:0] A_CTRL = 16'h0008;
  localparam logic [15:0] A_STAT = 16'h000C;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Memory contents seen by the slave model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0101};
  endfunction

  // -------------------------------------------------------------------------
  // AXI read slave + FIFO monitor. Drives on the falling edge, then records
  // the handshakes that the next rising edge will complete.
  // -------------------------------------------------------------------------
  int          cyc = 0;
  int          ar_count = 0;
  int          push_count = 0;
  int          arvalid_cycles = 0;
  int          stab_fail = 0;
  int          ar_delay = 0;
  int          err_beat = -1;
  logic [31:0] ar_log[$];
  int          hs_cyc[$];
  logic [31:0] exp_q[$];
  int          s_phase = 0;
  int          s_beat = 0;
  int          s_wait = 0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_hold = '0;

  initial begin
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RDATA   = '0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARST) begin
        s_phase = 0; s_beat = 0; s_wait = 0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
      end else if (s_phase == 0) begin
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
        if (M_AXI_ARVALID) begin
          arvalid_cycles++;
          if (s_wait == 0) s_hold = M_AXI_ARADDR;
          else if (M_AXI_ARADDR !== s_hold) stab_fail++;
          M_AXI_ARREADY = (s_wait >= ar_delay);
          s_wait++;
        end else begin
          M_AXI_ARREADY = 1'b0;
        end
      end else begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = mem_word(s_addr + 32'(4 * s_beat));
        M_AXI_RLAST   = (s_beat == 3);
        M_AXI_RRESP   = (s_beat == err_beat) ? 2'b10 : 2'b00;
      end
      #1;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_count++;
        ar_log.push_back(M_AXI_ARADDR);
        hs_cyc.push_back(cyc);
        for (int i = 0; i < 4; i++) exp_q.push_back(mem_word(M_AXI_ARADDR + 32'(4 * i)));
        s_addr = M_AXI_ARADDR; s_phase = 1; s_beat = 0; s_wait = 0;
      end
      if (FIFO_WREN) begin
        push_count++;
        check("push_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("push_data", FIFO_WDATA, exp_q.pop_front());
        if (s_phase == 1) begin
          if (s_beat == 3) s_phase = 0;
          else s_beat++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Register bus helpers; all are entered on a falling edge.
  // -------------------------------------------------------------------------
  task automatic reg_wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    @(negedge ACLK);
    WREN = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [31:0] d);
    RDADDR = a; RDEN = 1'b1;
    @(negedge ACLK);
    RDEN = 1'b0;
    d = RDATA;
  endtask

  task automatic clear_mon();
    ar_count = 0; push_count = 0; arvalid_cycles = 0; stab_fail = 0;
    ar_log.delete(); hs_cyc.delete();
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    bit          done;
    done = 0;
    repeat (4) @(negedge ACLK);
    for (int i = 0; i < 400; i++) begin
      reg_rd(A_STAT, d);
      if (!d[0]) begin
        done = 1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] d;
    int          busy_zero;
    int          budget;

    WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
    RDADDR = '0; RDEN = 1'b0; FIFO_FREE = 10'd64;

    // register vectors: optional write, then read back the same address
    vecs[0]  = '{1'b0, A_ADDR, 4'h0, 32'h0,          32'h0};
    vecs[1]  = '{1'b0, A_SIZE, 4'h0, 32'h0,          32'h0};
    vecs[2]  = '{1'b0, A_CTRL, 4'h0, 32'h0,          32'h0};
    vecs[3]  = '{1'b0, A_STAT, 4'h0, 32'h0,          32'h0};
    vecs[4]  = '{1'b1, A_ADDR, 4'hF, 32'h1234_5678,  32'h1234_5670};
    vecs[5]  = '{1'b1, A_ADDR, 4'h1, 32'h0000_00FF,  32'h1234_56F0};
    vecs[6]  = '{1'b1, A_ADDR, 4'h8, 32'hAB00_0000,  32'hAB34_56F0};
    vecs[7]  = '{1'b1, A_ADDR, 4'h0, 32'hFFFF_FFFF,  32'hAB34_56F0};
    vecs[8]  = '{1'b1, A_SIZE, 4'hF, 32'h0000_ABCD,  32'h0000_ABC0};
    vecs[9]  = '{1'b1, A_SIZE, 4'h2, 32'h0000_1200,  32'h0000_12C0};
    vecs[10] = '{1'b1, A_CTRL, 4'hF, 32'h0000_0002,  32'h0000_0002};
    vecs[11] = '{1'b1, A_STAT, 4'hF, 32'hFFFF_FFFF,  32'h0000_0000};
    vecs[12] = '{1'b1, 16'h0010, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{1'b0, A_CTRL, 4'h0, 32'h0,          32'h0000_0002};
    vecs[14] = '{1'b1, A_CTRL, 4'h0, 32'h0000_0001,  32'h0000_0002};

    repeat (3) @(negedge ACLK);
    ARST = 1'b0;
    @(negedge ACLK);

    // reset state and constant outputs
    check("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("rst_rready",  32'(M_AXI_RREADY),  32'd0);
    check("rst_wren",    32'(FIFO_WREN),     32'd0);
    check("rst_wdata",   FIFO_WDATA,         32'd0);
    check("rst_rdata",   RDATA,              32'd0);
    check("rst_araddr",  M_AXI_ARADDR,       32'd0);
    check("arlen",       32'(M_AXI_ARLEN),   32'd3);
    check("arsize",      32'(M_AXI_ARSIZE),  32'd2);
    check("arburst",     32'(M_AXI_ARBURST), 32'd1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) reg_wr(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      reg_rd(vecs[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
    end
    reg_wr(A_CTRL, 4'hF, 32'h0);

    // basic transfer: 4 bursts, 16 pushes, ENABLE self-clears
    reg_wr(A_ADDR, 4'hF, 32'h1000_0000);
    reg_wr(A_SIZE, 4'hF, 32'h0000_0040);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h1);
    check("start_lat_c1", 32'(M_AXI_ARVALID), 32'd0);
    @(negedge ACLK);
    check("start_lat_c2", 32'(M_AXI_ARVALID), 32'd0);
    @(negedge ACLK);
    check("start_lat_c3", 32'(M_AXI_ARVALID), 32'd1);
    check("start_araddr", M_AXI_ARADDR, 32'h1000_0000);
    wait_idle("basic_idle");
    check("basic_bursts", 32'(ar_count), 32'd4);
    check("basic_pushes", 32'(push_count), 32'd16);
    if (ar_count == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("basic_addr%0d", i), ar_log[i], 32'h1000_0000 + 32'(16 * i));
      check("burst_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd6);
      check("burst_gap23", 32'(hs_cyc[3] - hs_cyc[2]), 32'd6);
    end
    check("basic_expq_empty", 32'(exp_q.size()), 32'd0);
    reg_rd(A_CTRL, d);
    check("basic_enable_cleared", d, 32'h0);
    reg_rd(A_STAT, d);
    check("basic_stat", d, 32'h0);

    // backpressure: 3 free slots holds off, 4 releases exactly one burst
    FIFO_FREE = 10'd3;
    reg_wr(A_ADDR, 4'hF, 32'h2000_0000);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h1);
    repeat (100) @(negedge ACLK);
    check("bp_no_arvalid", 32'(arvalid_cycles), 32'd0);
    FIFO_FREE = 10'd4;
    budget = 0;
    while (ar_count < 1 && budget < 50) begin
      @(negedge ACLK);
      budget++;
    end
    FIFO_FREE = 10'd3;
    check("bp_burst_seen", 32'(ar_count), 32'd1);
    repeat (30) @(negedge ACLK);
    check("bp_one_burst", 32'(ar_count), 32'd1);
    check("bp_pushes", 32'(push_count), 32'd4);
    if (ar_count >= 1) check("bp_addr", ar_log[0], 32'h2000_0000);
    reg_wr(A_CTRL, 4'hF, 32'h0);
    wait_idle("bp_idle");
    FIFO_FREE = 10'd64;

    // loop over a 2-burst buffer; BUSY must never drop
    reg_wr(A_ADDR, 4'hF, 32'h3000_0000);
    reg_wr(A_SIZE, 4'hF, 32'h0000_0020);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h3);
    repeat (4) @(negedge ACLK);
    busy_zero = 0;
    for (int i = 0; i < 500; i++) begin
      reg_rd(A_STAT, d);
      if (!d[0]) busy_zero++;
      if (ar_count >= 6) break;
    end
    check("loop_busy_held", 32'(busy_zero), 32'd0);
    check("loop_bursts", 32'(ar_count >= 6), 32'd1);
    if (ar_count >= 6) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("loop_addr%0d", i), ar_log[i],
              (i % 2 == 1) ? 32'h3000_0010 : 32'h3000_0000);
    end
    reg_wr(A_CTRL, 4'hF, 32'h0);
    wait_idle("loop_idle");
    check("loop_whole_bursts", 32'(push_count), 32'(4 * ar_count));

    // stop mid-burst: clear ENABLE after beat 2
    reg_wr(A_ADDR, 4'hF, 32'h4000_0000);
    reg_wr(A_SIZE, 4'hF, 32'h0000_0040);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h1);
    budget = 0;
    while (push_count < 2 && budget < 50) begin
      @(negedge ACLK);
      budget++;
    end
    check("stop_reached_beat2", 32'(push_count), 32'd2);
    reg_wr(A_CTRL, 4'hF, 32'h0);
    reg_rd(A_STAT, d);
    check("stop_busy_in_data", 32'(d[0]), 32'd1);
    reg_rd(A_STAT, d);
    check("stop_busy_in_wait", 32'(d[0]), 32'd1);
    reg_rd(A_STAT, d);
    check("stop_idle_2_after_rlast", 32'(d[0]), 32'd0);
    repeat (20) @(negedge ACLK);
    check("stop_bursts", 32'(ar_count), 32'd1);
    check("stop_pushes", 32'(push_count), 32'd4);
    check("stop_no_arvalid", 32'(M_AXI_ARVALID), 32'd0);

    // error response on beat 1 plus ARREADY held off 5 cycles
    ar_delay = 5;
    err_beat = 1;
    reg_wr(A_ADDR, 4'hF, 32'h5000_0000);
    reg_wr(A_SIZE, 4'hF, 32'h0000_0010);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h1);
    wait_idle("err_idle");
    check("err_bursts", 32'(ar_count), 32'd1);
    check("err_pushes", 32'(push_count), 32'd4);
    check("err_arvalid_cycles", 32'(arvalid_cycles), 32'd6);
    check("err_araddr_stable", 32'(stab_fail), 32'd0);
    reg_rd(A_STAT, d);
    check("err_resperr_set", d, 32'h2);
    ar_delay = 0;
    err_beat = -1;
    reg_wr(A_CTRL, 4'hF, 32'h1);
    reg_rd(A_STAT, d);
    check("err_resperr_cleared", 32'(d[1]), 32'd0);
    wait_idle("err_rerun_idle");
    check("err_rerun_pushes", 32'(push_count), 32'd8);
    reg_rd(A_STAT, d);
    check("err_stat_final", d, 32'h0);

    // synchronous reset during DATA
    reg_wr(A_ADDR, 4'hF, 32'h6000_0000);
    reg_wr(A_SIZE, 4'hF, 32'h0000_0040);
    reg_rd(A_ADDR, d);
    clear_mon();
    reg_wr(A_CTRL, 4'hF, 32'h1);
    budget = 0;
    while (push_count < 1 && budget < 50) begin
      @(negedge ACLK);
      budget++;
    end
    check("rstm_in_data", 32'(M_AXI_RREADY), 32'd1);
    ARST = 1'b1;
    @(negedge ACLK);
    check("rstm_strobes", {29'd0, M_AXI_ARVALID, M_AXI_RREADY, FIFO_WREN}, 32'd0);
    check("rstm_wdata",  FIFO_WDATA,   32'd0);
    check("rstm_rdata",  RDATA,        32'd0);
    check("rstm_araddr", M_AXI_ARADDR, 32'd0);
    repeat (2) @(negedge ACLK);
    ARST = 1'b0;
    exp_q.delete();
    @(negedge ACLK);
    reg_rd(A_ADDR, d);
    check("rstm_sndaddr", d, 32'h0);
    reg_rd(A_CTRL, d);
    check("rstm_sndctrl", d, 32'h0);

    // zero-size start is ignored
    clear_mon();
    reg_wr(A_ADDR, 4'hF, 32'h7000_0000);
    reg_wr(A_CTRL, 4'hF, 32'h1);
    repeat (20) @(negedge ACLK);
    check("zero_no_arvalid", 32'(arvalid_cycles), 32'd0);
    check("zero_no_burst", 32'(ar_count), 32'd0);
    reg_rd(A_STAT, d);
    check("zero_not_busy", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snd_dma_ctrl.md
# snd_dma_ctrl

Read-DMA scheduler for the sound subsystem. It fetches PCM samples from a DDR buffer over the AXI master read channel and pushes them into the sound output FIFO that feeds the I2S serializer. It sequences fixed 4-beat bursts only while the FIFO has room, and optionally loops over the buffer. Software configures and monitors it through the register bus; it sits between the regbus decoder, the AXI interconnect and the sample FIFO inside the sound top level.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width; one sample word (L16+R16) per beat
- C_FIFO_CNT_WIDTH, 10, width of the FIFO free-space count
- ACLK  in  1  system clock; every output and register lives in this domain
- ARST  in  1  reset, synchronous, active-high
- M_AXI_ARADDR  out  32  burst start address
- M_AXI_ARLEN  out  8  constant 3 (4 beats)
- M_AXI_ARSIZE  out  3  constant 2 (4 bytes)
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address accepted
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat
- M_AXI_RVALID  in  1  data valid
- M_AXI_RREADY  out  1  data ready
- FIFO_FREE  in  C_FIFO_CNT_WIDTH  free word slots in the sample FIFO
- FIFO_WREN  out  1  FIFO push strobe
- FIFO_WDATA  out  32  FIFO push data
- WRADDR  in  16  register write address
- BYTEEN  in  4  write byte enables
- WREN  in  1  write strobe
- WDATA  in  32  write data
- RDADDR  in  16  register read address
- RDEN  in  1  read strobe
- RDATA  out  32  read data

## Operation
- Registers (byte offsets; BYTEEN honoured per byte):
  - 0x0000 SNDADDR: buffer base address. Bits [3:0] read as 0 and are forced to 0.
  - 0x0004 SNDSIZE: buffer length in bytes. Bits [3:0] are forced to 0.
  - 0x0008 SNDCTRL: bit0 ENABLE, bit1 LOOP.
  - 0x000C SNDSTAT (read-only): bit0 BUSY, bit1 RESPERR (sticky; cleared by writing SNDCTRL with ENABLE=1).
- Unmapped read addresses return 0.
- Internal state: cur_addr, remain (bytes left).
  - Both are loaded from SNDADDR/SNDSIZE on the ENABLE 0->1 edge and at each loop wrap.
  - Register writes made while BUSY take effect only at the next load.
- FSM states: IDLE, WAIT, ADDR, DATA.
  - IDLE: BUSY=0. On an ENABLE rising edge with SNDSIZE≠0: load, then go to WAIT. With SNDSIZE=0 the edge is ignored.
  - WAIT: if ENABLE=0, go to IDLE. Else if FIFO_FREE≥4, go to ADDR.
  - ADDR: ARVALID=1 and ARADDR=cur_addr, held stable until ARREADY. On the handshake, go to DATA.
  - DATA: RREADY=1. Every RVALID&RREADY beat pushes one word. When the beat with RLAST set completes:
    - cur_addr += 16 and remain -= 16.
    - If remain reaches 0 with LOOP=1: reload, then go to WAIT.
    - If remain reaches 0 with LOOP=0: clear ENABLE, then go to IDLE.
    - Otherwise go to WAIT.
- A burst starts only when FIFO_FREE≥4, so it can never overflow the FIFO.
- Clearing ENABLE in ADDR or DATA does not abort the transfer. The outstanding burst completes in full (all 4 beats pushed) and the FSM then goes to IDLE. An AXI transaction is never abandoned.
- Any beat with RRESP≠0 sets RESPERR. The data is still pushed and the transfer continues.
- Bursts are 16-byte aligned, so they never cross a 4 KB boundary.
- cur_addr wraps modulo 2^32 without special handling.

## Timing
- Reset values:
  - ARVALID=0, RREADY=0, FIFO_WREN=0, FIFO_WDATA=0, RDATA=0, ARADDR=0.
  - All registers are 0 and the FSM is in IDLE.
- ARST is sampled on ACLK only. Asserting it mid-burst drops ARVALID and RREADY on the next edge. The interconnect is reset together with this block.
- Constant outputs: ARLEN=3, ARSIZE=2, ARBURST=2'b01.
- Handshake timing:
  - ARVALID rises on the first cycle in ADDR.
  - ARVALID never drops before ARREADY, and drops the cycle after the handshake.
- FIFO push is combinational: FIFO_WREN = RVALID & RREADY, and FIFO_WDATA = RDATA in the same cycle.
- ENABLE edge to ARVALID: 2 cycles minimum (IDLE→WAIT→ADDR).
- RLAST beat to the next ARVALID: 2 cycles minimum (DATA→WAIT→ADDR).
- Register write to the register update: the next edge. RDATA is registered and valid the cycle after RDEN.
- Simultaneous regbus write and internal clear of ENABLE (end of buffer, LOOP=0): the software write wins.

## Test plan
- Basic transfer: SNDADDR=0x1000_0000, SNDSIZE=0x40, ENABLE=1, FIFO_FREE=64, slave with zero wait states -> exactly 4 bursts at addresses 0x1000_0000/10/20/30, 16 FIFO pushes with data matching memory in order, then ENABLE=0 and BUSY=0.
- Backpressure: FIFO_FREE=3 for 100 cycles, then 4 -> no ARVALID during the 100 cycles; exactly one burst is issued after FIFO_FREE reaches 4.
- Loop: SNDSIZE=0x20, LOOP=1 -> address sequence …00, …10, …00, …10 repeating; BUSY stays 1 throughout.
- Stop mid-burst: clear ENABLE after the 2nd beat -> beats 3 and 4 are still accepted and pushed, no further ARVALID, IDLE 2 cycles after RLAST.
- Error and stalls: RRESP=2'b10 on one beat, and ARREADY delayed 5 cycles -> RESPERR=1, ARADDR held stable during the delay, all 4 words pushed; writing ENABLE=1 clears RESPERR.
- Reset mid-burst, and zero-size start: asserting ARST during DATA gives all outputs 0 on the next edge; ENABLE with SNDSIZE=0 produces no ARVALID.
